line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Main-memory responder on the far end of the data-cache refill/writeback interface of the cpu5 core.
- The cache controller is the initiator. It issues one line-granular request: a refill read or a writeback write.
- This block accepts the request, waits a programmable access latency, then streams or absorbs one full cache line of words.
- It replaces the ideal single-cycle data memory in cache-control benches, so hit/miss timing is observable and deterministic.

Parameters:
- ADDR_W, 32: byte-address width of req_addr.
- DATA_W, 32: word width of rd_data / wr_data.
- WORDS_PER_LINE, 4: beats per line. Power of two, >= 2.
- DEPTH_WORDS, 1024: backing array depth in words. Power of two. Array named mem so benches can preload it with $readmemh.
- LATENCY, 4: cycles from request acceptance to the first data beat. Must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept. High only in IDLE.
- req_write  in  1  1 = writeback line, 0 = refill line.
- req_addr  in  ADDR_W  byte address. Line offset bits are ignored (forced line-aligned).
- rd_valid  out  1  refill beat valid. No backpressure.
- rd_data  out  DATA_W  refill beat data.
- rd_last  out  1  marks the final refill beat.
- wr_valid  in  1  writeback beat offered.
- wr_ready  out  1  responder accepts writeback beats.
- wr_data  in  DATA_W  writeback beat data.
- wr_done  out  1  one-cycle pulse: writeback line committed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state = IDLE; beat and latency counters = 0.
  - rd_valid, rd_last, wr_ready, wr_done, busy = 0; rd_data = 0.
  - req_ready = 1 once rst_ is high.
  - mem contents are never cleared by reset.
  - Reset mid-burst aborts the transaction immediately. A partially written line keeps the beats already committed.
- All outputs are registered except req_ready and busy, which decode directly from state.
- Address math:
  - word index = req_addr[ADDR_W-1:2].
  - line base = word index with its low log2(WORDS_PER_LINE) bits cleared, taken modulo DEPTH_WORDS (upper bits dropped, silent wrap).
  - beat k addresses base+k. k never crosses the line boundary.
- States: IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid=1: capture base and req_write, load latency counter = LATENCY-1, go to WAIT.
  - req_valid while not in IDLE is ignored and not queued. The initiator holds it until it sees req_ready.
- WAIT:
  - Decrement the counter each edge.
  - When the counter reaches 0: go to RD_BURST if the request was a read, else WR_BURST. Beat counter = 0.
- RD_BURST:
  - Request accepted at edge E0: rd_valid is high in the WORDS_PER_LINE consecutive cycles following edges E0+LATENCY through E0+LATENCY+WORDS_PER_LINE-1.
  - rd_data = mem[base+beat].
  - rd_last is high with the final beat only.
  - The state returns to IDLE at edge E0+LATENCY+WORDS_PER_LINE, so req_ready is high in the cycle after the last beat.
- WR_BURST:
  - wr_ready = 1 from the cycle after edge E0+LATENCY.
  - Each edge with wr_valid && wr_ready writes wr_data to mem[base+beat] and increments beat.
  - Gaps in wr_valid stall the burst indefinitely. There is no timeout.
  - After the beat with index WORDS_PER_LINE-1 is accepted: wr_ready drops next cycle and the state goes to WR_ACK.
- WR_ACK: wr_done = 1 for exactly one cycle, then IDLE.
- Ordering: a read immediately following a write to the same line returns the new data. The write is committed before WR_ACK.
- wr_valid outside WR_BURST is ignored, with no side effect on mem.

Decomposition:
- Package line_mem_pkg holds:
  - state enum lm_state_t {IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK};
  - localparams for line-offset bits and word-index width, derived via $clog2.
- One sub-module: lm_sram, a single-port synchronous RAM.
  - One write port plus a registered read, sized DEPTH_WORDS x DATA_W.
  - Holds the array mem.
  - The responder pre-issues each read address one cycle ahead, so rd_data aligns with rd_valid.

Test Plan:
- Reset values: hold rst_ low 2 cycles → req_ready=1 after release; rd_valid=wr_ready=wr_done=busy=0; preloaded mem[0..3]=A0..A3 unchanged.
- Refill timing: read req_addr=0x0 accepted at edge E0, LATENCY=4 → rd_data A0,A1,A2,A3 in cycles after E0+4..E0+7; rd_last only with A3; req_ready high after E0+8.
- Writeback with stalls: write req_addr=0x14 (line base word 4), wr_valid pattern 1,0,1,1,0,1 with data B0..B3 → mem[4..7]=B0..B3; one wr_done pulse; then a read of 0x10 returns B0..B3.
- Busy rejection: assert a second req_valid during WAIT and RD_BURST → not accepted until IDLE; exactly one rd_last per accepted request.
- Reset mid-write: rst_ low after 2 of 4 beats → IDLE immediately, no wr_done; mem[4],mem[5] updated, mem[6],mem[7] hold old values.
- Address wrap: req_addr=4*DEPTH_WORDS+0x8 read → returns mem[0..3] (offset ignored, upper bits dropped).

Source files
------------

// File: rtl/line_mem_pkg.sv
// Shared types and default geometry for the line-granular memory responder.
// Line offset and word-index widths are derived so callers never hand-compute them.
package line_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST,
    WR_ACK
  } lm_state_t;

  localparam int LM_WORDS_PER_LINE = 4;
  localparam int LM_DEPTH_WORDS    = 1024;
  localparam int LM_OFF_BITS       = $clog2(LM_WORDS_PER_LINE);
  localparam int LM_IDX_W          = $clog2(LM_DEPTH_WORDS);

endpackage

// File: rtl/lm_sram.sv
// Single-port synchronous RAM: write on the clock edge, read data registered one cycle after i_re.
// No backpressure; mem is never cleared by reset so preloaded or written contents survive it.
module lm_sram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)     r_rdata <= '0;
    else if (i_re) r_rdata <= mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_mem_responder.sv
// Line memory responder: one refill/writeback line per request, first beat LATENCY cycles after accept.
// Refill beats have no backpressure; writeback stalls on wr_valid gaps; requests only accepted in IDLE.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = LM_WORDS_PER_LINE,
  parameter int DEPTH_WORDS    = LM_DEPTH_WORDS,
  parameter int LATENCY        = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              busy
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int LINE_W   = IDX_W - OFF_BITS;
  localparam int LAT_W    = $clog2(LATENCY + 1);
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS_PER_LINE - 1);

  lm_state_t           r_state, w_state_nxt;
  logic [LAT_W-1:0]    r_lat, w_lat_nxt;
  logic [OFF_BITS-1:0] r_beat, w_beat_nxt;
  logic [LINE_W-1:0]   r_line, w_line_nxt;
  logic                r_write, w_write_nxt;
  logic                r_rd_valid, w_rd_valid_nxt;
  logic                r_rd_last, w_rd_last_nxt;
  logic                r_wr_ready, w_wr_ready_nxt;
  logic                r_wr_done, w_wr_done_nxt;
  logic                w_sram_we, w_sram_re;
  logic [OFF_BITS-1:0] w_offset;
  logic                w_unused;

  // Offset bits and address bits above the array depth are dropped: silent wrap.
  assign w_unused = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[OFF_BITS+1:0]};

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= IDLE;
      r_lat      <= '0;
      r_beat     <= '0;
      r_line     <= '0;
      r_write    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_wr_ready <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat      <= w_lat_nxt;
      r_beat     <= w_beat_nxt;
      r_line     <= w_line_nxt;
      r_write    <= w_write_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_last  <= w_rd_last_nxt;
      r_wr_ready <= w_wr_ready_nxt;
      r_wr_done  <= w_wr_done_nxt;
    end
  end

  // The RAM read is issued one cycle ahead of each beat so its registered output lines up with rd_valid.
  always_comb begin
    w_state_nxt    = r_state;
    w_lat_nxt      = r_lat;
    w_beat_nxt     = r_beat;
    w_line_nxt     = r_line;
    w_write_nxt    = r_write;
    w_rd_valid_nxt = 1'b0;
    w_rd_last_nxt  = 1'b0;
    w_wr_ready_nxt = 1'b0;
    w_wr_done_nxt  = 1'b0;
    w_sram_we      = 1'b0;
    w_sram_re      = 1'b0;
    w_offset       = r_beat;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = WAIT;
          w_lat_nxt   = LAT_W'(LATENCY - 1);
          w_line_nxt  = req_addr[IDX_W+1:OFF_BITS+2];
          w_write_nxt = req_write;
        end
      end
      WAIT: begin
        if (r_lat == '0) begin
          w_beat_nxt = '0;
          if (r_write) begin
            w_state_nxt    = WR_BURST;
            w_wr_ready_nxt = 1'b1;
          end else begin
            w_state_nxt    = RD_BURST;
            w_rd_valid_nxt = 1'b1;
            w_sram_re      = 1'b1;
            w_offset       = '0;
          end
        end else begin
          w_lat_nxt = r_lat - 1'b1;
        end
      end
      RD_BURST: begin
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = IDLE;
        end else begin
          w_beat_nxt     = r_beat + 1'b1;
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = ((r_beat + 1'b1) == LAST_BEAT);
          w_sram_re      = 1'b1;
          w_offset       = r_beat + 1'b1;
        end
      end
      WR_BURST: begin
        w_wr_ready_nxt = 1'b1;
        if (wr_valid && r_wr_ready) begin
          w_sram_we  = 1'b1;
          w_beat_nxt = r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt    = WR_ACK;
            w_wr_ready_nxt = 1'b0;
            w_wr_done_nxt  = 1'b1;
          end
        end
      end
      WR_ACK:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  lm_sram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (IDX_W)
  ) u_sram (
    .clk     (clk),
    .rst_    (rst_),
    .i_we    (w_sram_we),
    .i_re    (w_sram_re),
    .i_addr  ({r_line, w_offset}),
    .i_wdata (wr_data),
    .o_rdata (rd_data)
  );

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign wr_ready  = r_wr_ready;
  assign wr_done   = r_wr_done;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboarded bench for line_mem_responder: directed refill/writeback vectors, expected beats queued at issue.
module tb_line_mem_responder;

  logic        clk;
  logic        rst_;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_last  = 0;
  int n_done_cycles = 0;
  logic [32:0] rd_exp_q[$];

  line_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4), .DEPTH_WORDS(1024), .LATENCY(4)
  ) dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expected {last,data} per presented refill beat.
  always @(negedge clk) begin
    if (rst_) begin
      if (rd_valid) begin
        if (rd_last) n_last++;
        if (rd_exp_q.size() == 0) chk("rd_unexpected_beat", {rd_last, rd_data}, 33'h0);
        else chk("rd_beat", {rd_last, rd_data}, rd_exp_q.pop_front());
      end
      if (wr_done) n_done_cycles++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_line(input logic [31:0] base_val);
    for (int i = 0; i < 4; i++) rd_exp_q.push_back({(i == 3), base_val + 32'(i)});
  endtask

  task automatic push_vals(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    rd_exp_q.push_back({1'b0, d0});
    rd_exp_q.push_back({1'b0, d1});
    rd_exp_q.push_back({1'b0, d2});
    rd_exp_q.push_back({1'b1, d3});
  endtask

  // Returns 1ns after the accepting edge with req_valid dropped.
  task automatic req_issue(input logic [31:0] addr, input logic wr);
    int n;
    @(negedge clk);
    req_addr = addr; req_write = wr; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("req_accept_timeout", 33'(n), 33'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 33'(n), 33'd0);
  endtask

  task automatic wait_wr_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("wr_ready_timeout", 33'(n), 33'd0);
  endtask

  // pat is consumed LSB first, cyclically: 1 = offer a beat this cycle, 0 = gap.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] base_val, input logic [5:0] pat);
    int beat, p, cyc;
    logic acc;
    req_issue(addr, 1'b1);
    wait_wr_ready();
    beat = 0; p = 0; cyc = 0;
    while (beat < 4 && cyc < 100) begin
      wr_valid = pat[p % 6];
      wr_data  = base_val + 32'(beat);
      acc = wr_valid && wr_ready;
      p++; cyc++;
      @(negedge clk);
      if (acc) beat++;
    end
    wr_valid = 1'b0;
    chk("wr_beats_accepted", 33'(beat), 33'd4);
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] addr);
    req_issue(addr, 1'b0);
    wait_idle();
  endtask

  initial begin
    int n;
    rst_ = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0;
    #2 rst_ = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", 33'(rd_valid), 33'd0);
    chk("rst_rd_last",  33'(rd_last),  33'd0);
    chk("rst_rd_data",  33'(rd_data),  33'd0);
    chk("rst_wr_ready", 33'(wr_ready), 33'd0);
    chk("rst_wr_done",  33'(wr_done),  33'd0);
    chk("rst_busy",     33'(busy),     33'd0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 33'(req_ready), 33'd1);
    chk("post_rst_busy",      33'(busy),      33'd0);

    // Preload line 0 with A0..A3, then reset again: contents must survive.
    do_write(32'h0, 32'hA000_0000, 6'b111111);
    @(negedge clk) rst_ = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;

    // Refill timing: beats in cycles after E0+4..E0+7, req_ready after E0+8.
    push_line(32'hA000_0000);
    req_issue(32'h0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rd_valid_k%0d", k),  33'(rd_valid),  33'((k >= 4 && k <= 7) ? 1 : 0));
      chk($sformatf("req_ready_k%0d", k), 33'(req_ready), 33'((k == 8) ? 1 : 0));
    end
    chk("busy_after_refill", 33'(busy), 33'd0);

    // Writeback with stalls to 0x14 (line base word 4), then refill 0x10.
    do_write(32'h14, 32'hB000_0000, 6'b101101);
    push_line(32'hB000_0000);
    do_read(32'h10);

    // Second request held during WAIT/RD_BURST: accepted only once IDLE.
    push_line(32'hB000_0000);
    push_line(32'hA000_0000);
    @(negedge clk);
    req_addr = 32'h10; req_write = 1'b0; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_addr = 32'h0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin n++; @(negedge clk); end
    chk("busy_hold_cycles", 33'(n), 33'd8);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    // Reset after 2 of 4 writeback beats: C0,C1 land, words 6,7 keep B2,B3.
    req_issue(32'h10, 1'b1);
    wait_wr_ready();
    wr_valid = 1'b1; wr_data = 32'hC000_0000;
    @(negedge clk);
    wr_data = 32'hC000_0001;
    @(posedge clk); #1;
    rst_ = 1'b0; wr_valid = 1'b0;
    #1;
    chk("midrst_busy",     33'(busy),     33'd0);
    chk("midrst_wr_ready", 33'(wr_ready), 33'd0);
    chk("midrst_wr_done",  33'(wr_done),  33'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 33'(req_ready), 33'd1);
    push_vals(32'hC000_0000, 32'hC000_0001, 32'hB000_0002, 32'hB000_0003);
    do_read(32'h10);

    // Wrapped, misaligned address reads line 0; stray wr_valid must not touch mem.
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    push_line(32'hA000_0000);
    do_read(32'h0000_1008);
    wr_valid = 1'b0;
    push_line(32'hA000_0000);
    do_read(32'h0);

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 33'(rd_exp_q.size()), 33'd0);
    chk("rd_last_count",    33'(n_last),          33'd7);
    chk("wr_done_cycles",   33'(n_done_cycles),   33'd2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
